spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_slave_if.sv | 23 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave block.
package spi_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   localparam int BYTE_W = 8;
   localparam int CNT_W  = $clog2(BYTE_W);

   // Byte shifted out when the host has not supplied one in time.
   localparam logic [BYTE_W-1:0] EMPTY_FILL = '1;

endpackage

// File: rtl/spi_slave_if.sv
// Host-side byte handshake of the SPI slave: TX holding register and RX buffer.
interface spi_slave_if;
   import spi_pkg::*;

   logic [BYTE_W-1:0] tx_data;
   logic              tx_load;
   logic              tx_ready;
   logic [BYTE_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ack;
   logic              overrun;

   modport master (
      output tx_data, tx_load, rx_ack,
      input  tx_ready, rx_data, rx_valid, overrun
   );

   modport slave (
      input  tx_data, tx_load, rx_ack,
      output tx_ready, rx_data, rx_valid, overrun
   );

endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous pin with one-cycle rise/fall pulses.
module spi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic init,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_reg;
   logic              prev_reg;
   logic              level;

   // Reset loads the pin's idle level so no false edge appears on release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_reg <= {STAGES{init}};
         prev_reg <= init;
      end else begin
         sync_reg <= {sync_reg[STAGES-2:0], din};
         prev_reg <= sync_reg[STAGES-1];
      end
   end

   assign level = sync_reg[STAGES-1];
   assign rise  = level & ~prev_reg;
   assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_slave.sv
// Oversampling SPI slave, all four modes, one byte of TX holding and RX buffering.
module spi_slave
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic cpol,
   input  logic cpha,
   input  logic sclk,
   input  logic ss_n,
   input  logic mosi,
   output logic miso,
   output logic miso_oe,
   spi_slave_if.slave host
);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   bit_cnt_reg;
   logic [BYTE_W-1:0]  rx_shift_reg;
   logic [BYTE_W-1:0]  tx_shift_reg;
   logic [BYTE_W-1:0]  tx_hold_reg;
   logic               tx_ready_reg;
   logic [BYTE_W-1:0]  rx_data_reg;
   logic               rx_valid_reg;
   logic               overrun_reg;
   logic               byte_done_reg;
   logic [SYNC_STAGES-1:0] mosi_sync_reg;

   logic sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic lead_edge, trail_edge, sample_edge, shift_edge;
   logic do_sample, do_shift, byte_done, load_tx, abort;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk   (clk),
      .reset (reset),
      .init  (cpol),
      .din   (sclk),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
      .clk   (clk),
      .reset (reset),
      .init  (1'b1),
      .din   (ss_n),
      .rise  (ss_rise),
      .fall  (ss_fall)
   );

   // Same depth as the sclk path, so mosi is aligned with the edge pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) mosi_sync_reg <= '0;
      else       mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
   end

   assign lead_edge   = cpol ? sclk_fall : sclk_rise;
   assign trail_edge  = cpol ? sclk_rise : sclk_fall;
   assign sample_edge = cpha ? trail_edge : lead_edge;
   assign shift_edge  = cpha ? lead_edge  : trail_edge;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      load_tx    = 1'b0;
      abort      = 1'b0;
      do_sample  = 1'b0;
      do_shift   = 1'b0;
      byte_done  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (ss_fall) begin
               state_next = XFER;
               load_tx    = 1'b1;
            end
         end
         XFER: begin
            if (ss_rise) begin
               state_next = IDLE;
               abort      = 1'b1;
            end else begin
               do_sample = sample_edge;
               do_shift  = shift_edge;
               byte_done = sample_edge && (bit_cnt_reg == CNT_W'(BYTE_W-1));
               load_tx   = byte_done;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt_reg   <= '0;
         rx_shift_reg  <= '0;
         byte_done_reg <= 1'b0;
      end else begin
         byte_done_reg <= byte_done;
         if (abort) begin
            bit_cnt_reg <= '0;
         end else if (do_sample) begin
            bit_cnt_reg  <= bit_cnt_reg + CNT_W'(1);
            rx_shift_reg <= {rx_shift_reg[BYTE_W-2:0], mosi_sync_reg[SYNC_STAGES-1]};
         end
      end
   end

   // A shift edge seen with the counter at zero is either the cpha=1 edge that
   // exposes bit 7 or the cpha=0 trailing edge after the last bit; both must
   // leave the freshly loaded byte untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_shift_reg <= '0;
         tx_hold_reg  <= '0;
         tx_ready_reg <= 1'b1;
      end else begin
         if (load_tx)
            tx_shift_reg <= tx_ready_reg ? EMPTY_FILL : tx_hold_reg;
         else if (do_shift && bit_cnt_reg != '0)
            tx_shift_reg <= {tx_shift_reg[BYTE_W-2:0], 1'b0};

         if (load_tx && !tx_ready_reg) begin
            tx_ready_reg <= 1'b1;
         end else if (host.tx_load && tx_ready_reg) begin
            tx_hold_reg  <= host.tx_data;
            tx_ready_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_data_reg  <= '0;
         rx_valid_reg <= 1'b0;
         overrun_reg  <= 1'b0;
      end else if (byte_done_reg && (!rx_valid_reg || host.rx_ack)) begin
         rx_data_reg  <= rx_shift_reg;
         rx_valid_reg <= 1'b1;
         overrun_reg  <= 1'b0;
      end else if (byte_done_reg) begin
         overrun_reg  <= 1'b1;
      end else if (host.rx_ack) begin
         rx_valid_reg <= 1'b0;
         overrun_reg  <= 1'b0;
      end
   end

   assign miso          = tx_shift_reg[BYTE_W-1];
   assign miso_oe       = (state_reg == XFER);
   assign host.tx_ready = tx_ready_reg;
   assign host.rx_data  = rx_data_reg;
   assign host.rx_valid = rx_valid_reg;
   assign host.overrun  = overrun_reg;

endmodule
